aes_ctr_encryptor: RTL and testbench
====================================

AES_CTR_ENCRYPTOR -- requirements
Module: aes_ctr_encryptor

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10: AES rounds per block; legal values are 10, 12 and 14.
REQ-002 SHALL have parameter CTR_WIDTH, default 32: number of low-order sync bits incremented per block; legal range is 8..128.
REQ-003 SHALL have parameter CTR_MODE, default 1: 1 advances the counter per block; 0 reuses one keystream block for the whole message.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port key_and_sync, dvr_key_if.slave (valid, rdy, key[127:0], sync[127:0]): key/IV load handshake.
REQ-007 SHALL have port msg_in, avalon_st_if.slave (data[127:0], valid, rdy, sop, eop, empty): plaintext stream.
REQ-008 SHALL have port msg_out, avalon_st_if.master (same fields): ciphertext stream.
REQ-009 SHALL have port double_sync, output, 1 bit: flags a key/sync offer that arrived while the block was busy.

Function
REQ-010 SHALL implement states WAIT_FOR_KEY_AND_SYNC, ENCRYPTION_PROCESS and WAIT_FOR_MSG in a registered state machine.
REQ-011 SHALL assert key_and_sync.rdy combinationally only in WAIT_FOR_KEY_AND_SYNC.
REQ-012 SHALL, on key_and_sync valid&rdy, latch key into key_reg and sync into ctr_reg, clear the round counter, and enter ENCRYPTION_PROCESS.
REQ-013 SHALL perform one AES round per cycle in ENCRYPTION_PROCESS using the aes_model_pack functions.
- cycle 0: state = ctr_reg ^ key_reg.
- rounds 1..NUM_ROUNDS-1: subbytes, shift_rows, mix_colums, then XOR with the expanded round key.
- final round: omits mix_colums.
REQ-014 SHALL expand round keys iteratively from key_reg, which is held unchanged until the next key load.
REQ-015 SHALL enter WAIT_FOR_MSG with the keystream register valid exactly NUM_ROUNDS+1 cycles after entering ENCRYPTION_PROCESS.
REQ-016 SHALL, in WAIT_FOR_MSG only, drive the message path combinationally:
- msg_in.rdy = msg_out.rdy
- msg_out.valid = msg_in.valid
- msg_out.data = msg_in.data ^ keystream
- sop, eop and empty passed through unmodified.
REQ-017 SHALL, outside WAIT_FOR_MSG, hold msg_in.rdy=0 and msg_out.valid=0; the other msg_out fields are don't-care.
REQ-018 SHALL, on an accepted beat (msg_in.valid & msg_out.rdy) with eop=1, return to WAIT_FOR_KEY_AND_SYNC.
REQ-019 SHALL, on an accepted beat with eop=0 and CTR_MODE=1, increment ctr_reg[CTR_WIDTH-1:0] modulo 2^CTR_WIDTH, leave the upper bits unchanged, and re-enter ENCRYPTION_PROCESS.
REQ-020 SHALL, on an accepted beat with eop=0 and CTR_MODE=0, stay in WAIT_FOR_MSG with the keystream unchanged.
REQ-021 SHALL wrap the counter from all-ones to zero in the low CTR_WIDTH bits with no carry into the upper bits and no flag.
REQ-022 SHALL register double_sync high for exactly one cycle after any cycle with key_and_sync.valid=1 and key_and_sync.rdy=0; the offered key/sync is ignored.
REQ-023 SHALL process a beat with sop=1 and eop=1 as a one-block message.
REQ-024 SHALL ignore key_and_sync.valid while a message is in progress; a new key/sync is taken only after eop.
REQ-025 SHALL tolerate msg_in.valid asserted during ENCRYPTION_PROCESS: no beat is accepted and data is not altered.

Reset
REQ-026 SHALL, while rst=0, asynchronously force:
- state = WAIT_FOR_KEY_AND_SYNC
- round counter, key_reg, ctr_reg, keystream = 0
- double_sync = 0
- msg_in.rdy = 0, msg_out.valid = 0
- key_and_sync.rdy = 1
REQ-027 SHALL, on reset asserted mid-encryption or mid-message, discard all partial state; the first beat after release requires a new key/sync load.

Verification
REQ-028 Bench SHALL cover:
- FIPS-197 vector: key 000102..0f, sync 00112233445566778899aabbccddeeff, one beat data 0 with sop=eop=1 -> msg_out.data = 69c4e0d86a7b0430d8cdb78070b4c55a, msg_out.valid 11 cycles after the key handshake.
- Three-beat message, CTR_MODE=1 -> beat n keystream = AES(key, sync+n) on the low 32 bits; after eop, state is WAIT_FOR_KEY_AND_SYNC and key_and_sync.rdy=1.
- sync low word ffffffff, two beats -> second keystream uses low word 00000000 with the upper 96 bits unchanged.
- key_and_sync.valid pulsed during ENCRYPTION_PROCESS -> double_sync=1 for one cycle; the output keystream still matches the original key.
- msg_out.rdy held 0 for 5 cycles in WAIT_FOR_MSG -> msg_in.rdy=0, no beat lost, ctr_reg unchanged; the beat is accepted on the cycle msg_out.rdy rises.
- rst pulsed low at round 4 -> all outputs at reset values immediately; a subsequent FIPS-197 run reproduces the vector.

Source files
------------

// File: rtl/aes_ctr_encryptor_if.sv
// ---------------------------------------------------------------------------
// Interfaces used by aes_ctr_encryptor.
//
// dvr_key_if   : key / initial counter (sync) load handshake.
//   valid  master->slave  offer present
//   rdy    slave->master  slave can take the offer this cycle
//   key    master->slave  128-bit AES key
//   sync   master->slave  128-bit initial counter block
//
// avalon_st_if : 128-bit Avalon-ST style streaming beat.
//   data   master->slave  payload
//   valid  master->slave  beat present
//   rdy    slave->master  beat is taken when valid & rdy
//   sop    master->slave  first beat of a message
//   eop    master->slave  last beat of a message
//   empty  master->slave  unused byte count on the eop beat
// ---------------------------------------------------------------------------
interface dvr_key_if;
    logic         valid;
    logic         rdy;
    logic [127:0] key;
    logic [127:0] sync;

    modport master (output valid, key, sync, input rdy);
    modport slave  (input valid, key, sync, output rdy);
endinterface

interface avalon_st_if;
    logic [127:0] data;
    logic         valid;
    logic         rdy;
    logic         sop;
    logic         eop;
    logic [3:0]   empty;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/aes_ctr_encryptor.sv
// ---------------------------------------------------------------------------
// aes_model_pack : AES round primitives (byte 0 of a block is bits [127:120],
// column c holds bytes 4c..4c+3).
//
// aes_ctr_encryptor : AES counter-mode stream encryptor, one round per clock.
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   key_and_sync key/counter load (slave)
//   msg_in       plaintext stream (slave)
//   msg_out      ciphertext stream (master), combinational from msg_in
//   double_sync  one-cycle flag: a key/sync was offered while busy
// Parameters: NUM_ROUNDS (10/12/14), CTR_WIDTH (8..128 low counter bits),
// CTR_MODE (1: new keystream block per beat, 0: one block per message).
// ---------------------------------------------------------------------------
package aes_model_pack;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] subbytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_colums(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for round 1..15 (x^(round-1) in GF(2^8)).
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 2; i < 16; i++)
            if (i <= int'(round)) r = xtime(r);
        return r;
    endfunction

    // One step of the 128-bit key schedule: previous round key -> next one.
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction
endpackage

module aes_ctr_encryptor #(
    parameter int NUM_ROUNDS = 10,
    parameter int CTR_WIDTH  = 32,
    parameter int CTR_MODE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    dvr_key_if.slave    key_and_sync,
    avalon_st_if.slave  msg_in,
    avalon_st_if.master msg_out,
    output logic        double_sync
);
    import aes_model_pack::*;

    localparam logic [1:0] WAIT_FOR_KEY_AND_SYNC = 2'd0;
    localparam logic [1:0] ENCRYPTION_PROCESS    = 2'd1;
    localparam logic [1:0] WAIT_FOR_MSG          = 2'd2;

    localparam logic [3:0]           LAST_ROUND = NUM_ROUNDS[3:0];
    localparam logic [CTR_WIDTH-1:0] CTR_ONE    = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]   state_reg;
    logic [3:0]   round_reg;
    logic [127:0] key_reg;
    logic [127:0] ctr_reg;
    logic [127:0] aes_state_reg;
    logic [127:0] round_key_reg;
    logic [127:0] keystream_reg;
    logic         double_sync_reg;

    logic         in_msg;
    logic         beat_accept;
    logic [127:0] sub_shift;
    logic [127:0] round_out;
    logic [127:0] expand_src;
    logic [127:0] round_key_next;
    logic [127:0] ctr_next;

    // Handshakes are pure decodes of the state, so reset drives them at once.
    assign key_and_sync.rdy = (state_reg == WAIT_FOR_KEY_AND_SYNC);
    assign in_msg           = (state_reg == WAIT_FOR_MSG);
    assign beat_accept      = in_msg & msg_in.valid & msg_out.rdy;

    assign msg_in.rdy    = in_msg & msg_out.rdy;
    assign msg_out.valid = in_msg & msg_in.valid;
    // Plaintext is not exposed on the output bus while no keystream is ready.
    assign msg_out.data  = in_msg ? (msg_in.data ^ keystream_reg) : '0;
    assign msg_out.sop   = msg_in.sop;
    assign msg_out.eop   = msg_in.eop;
    assign msg_out.empty = msg_in.empty;
    assign double_sync   = double_sync_reg;

    // Round datapath; the final round skips the column mix.
    assign sub_shift = shift_rows(subbytes(aes_state_reg));
    assign round_out = (round_reg == LAST_ROUND) ? (sub_shift ^ round_key_reg)
                                                 : (mix_colums(sub_shift) ^ round_key_reg);

    // Round keys are regenerated from key_reg for every block; key_reg itself
    // never changes until the next load. 12/14-round builds keep extending the
    // same 128-bit schedule.
    assign expand_src     = (round_reg == 4'd0) ? key_reg : round_key_reg;
    assign round_key_next = key_expand(expand_src, rcon(round_reg + 4'd1));

    always_comb begin
        ctr_next = ctr_reg;
        ctr_next[CTR_WIDTH-1:0] = ctr_reg[CTR_WIDTH-1:0] + CTR_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= WAIT_FOR_KEY_AND_SYNC;
            round_reg       <= '0;
            key_reg         <= '0;
            ctr_reg         <= '0;
            aes_state_reg   <= '0;
            round_key_reg   <= '0;
            keystream_reg   <= '0;
            double_sync_reg <= 1'b0;
        end else begin
            double_sync_reg <= key_and_sync.valid & (state_reg != WAIT_FOR_KEY_AND_SYNC);
            case (state_reg)
                WAIT_FOR_KEY_AND_SYNC: begin
                    if (key_and_sync.valid) begin
                        key_reg   <= key_and_sync.key;
                        ctr_reg   <= key_and_sync.sync;
                        round_reg <= '0;
                        state_reg <= ENCRYPTION_PROCESS;
                    end
                end
                ENCRYPTION_PROCESS: begin
                    round_key_reg <= round_key_next;
                    round_reg     <= round_reg + 4'd1;
                    if (round_reg == 4'd0) begin
                        aes_state_reg <= ctr_reg ^ key_reg;
                    end else if (round_reg == LAST_ROUND) begin
                        keystream_reg <= round_out;
                        state_reg     <= WAIT_FOR_MSG;
                    end else begin
                        aes_state_reg <= round_out;
                    end
                end
                WAIT_FOR_MSG: begin
                    if (beat_accept) begin
                        if (msg_in.eop) begin
                            state_reg <= WAIT_FOR_KEY_AND_SYNC;
                        end else if (CTR_MODE != 0) begin
                            ctr_reg   <= ctr_next;
                            round_reg <= '0;
                            state_reg <= ENCRYPTION_PROCESS;
                        end
                    end
                end
                default: state_reg <= WAIT_FOR_KEY_AND_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ctr_encryptor.sv
module tb_aes_ctr_encryptor;
    logic clk;
    logic rst;
    logic double_sync;

    dvr_key_if   ks_if();
    avalon_st_if in_if();
    avalon_st_if out_if();

    aes_ctr_encryptor dut (
        .clk          (clk),
        .rst          (rst),
        .key_and_sync (ks_if.slave),
        .msg_in       (in_if.slave),
        .msg_out      (out_if.master),
        .double_sync  (double_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;

    typedef struct {
        logic [127:0]      key;
        logic [127:0]      sync;
        logic [3:0][127:0] data;
        int                nbeats;
        int                stall;
        logic [127:0]      fixed0;
        bit                use_fixed;
    } vec_t;

    vec_t vecs[4];

    localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_SYNC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ------------------------------------------------------------------
    // Reference AES-128: table-based S-box built by brute-force inversion.
    // ------------------------------------------------------------------
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] xb, yb, inv, sb, cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yb = y[7:0];
                if (ref_gmul(xb, yb) == 8'h01) inv = yb;
            end
            for (int i = 0; i < 8; i++)
                sb[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbox_tab[x] = sb;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = ref_gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[rr+4*c] = sbox_tab[s[rr+4*((c+rr)%4)]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = ref_gmul(a0, 8'h02) ^ ref_gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ ref_gmul(a1, 8'h02) ^ ref_gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ ref_gmul(a2, 8'h02) ^ ref_gmul(a3, 8'h03);
                    s[4*c+3] = ref_gmul(a0, 8'h03) ^ a1 ^ a2 ^ ref_gmul(a3, 8'h02);
                end
            end else begin
                for (int j = 0; j < 16; j++) s[j] = t[j];
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Scoreboard consumer: every beat leaving the DUT must match the head.
    always @(negedge clk) begin
        if (rst && out_if.valid && out_if.rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h, want no beat", out_if.data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", out_if.data, mon_e.data);
                chk("beat_side", {122'h0, out_if.sop, out_if.eop, out_if.empty},
                    {122'h0, mon_e.sop, mon_e.eop, mon_e.empty});
            end
        end
    end

    task automatic key_load(input logic [127:0] k, input logic [127:0] s);
        int n;
        @(posedge clk); #1;
        ks_if.valid = 1'b1;
        ks_if.key   = k;
        ks_if.sync  = s;
        n = 0;
        @(negedge clk);
        while (!ks_if.rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("key_handshake_rdy", {127'h0, ks_if.rdy}, 128'h1);
        @(posedge clk); #1;
        ks_if.valid = 1'b0;
    endtask

    task automatic send_beats(input logic [127:0] key, input logic [127:0] sync,
                              input logic [3:0][127:0] data, input int nbeats, input int stall,
                              input logic [127:0] fixed0, input bit use_fixed);
        logic [127:0] ctr;
        beat_t        e;
        int           n;
        for (int b = 0; b < nbeats; b++) begin
            ctr = sync;
            ctr[31:0] = sync[31:0] + b[31:0];
            e.data  = (use_fixed && b == 0) ? fixed0 : (data[b] ^ ref_aes(key, ctr));
            e.sop   = (b == 0);
            e.eop   = (b == nbeats - 1);
            e.empty = b[3:0];
            exp_q.push_back(e);
            in_if.valid = 1'b1;
            in_if.data  = data[b];
            in_if.sop   = e.sop;
            in_if.eop   = e.eop;
            in_if.empty = e.empty;
            if (b == 0 && stall > 0) begin
                out_if.rdy = 1'b0;
                n = 0;
                @(negedge clk);
                while (!out_if.valid && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_valid_seen", {127'h0, out_if.valid}, 128'h1);
                for (int i = 0; i < stall; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("stall_in_rdy_low", {127'h0, in_if.rdy}, 128'h0);
                end
                @(posedge clk); #1;
                out_if.rdy = 1'b1;
                @(negedge clk);
                chk("stall_release_rdy", {127'h0, in_if.rdy}, 128'h1);
                @(posedge clk); #1;
            end else begin
                n = 0;
                @(negedge clk);
                while (!in_if.rdy && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                chk("beat_accept_rdy", {127'h0, in_if.rdy}, 128'h1);
                @(posedge clk); #1;
            end
        end
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        @(negedge clk);
        chk("idle_after_eop", {127'h0, ks_if.rdy}, 128'h1);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  leak;
        beat_t e;
        logic [3:0][127:0] zd;

        build_sbox();
        rst          = 1'b0;
        ks_if.valid  = 1'b0;
        ks_if.key    = '0;
        ks_if.sync   = '0;
        in_if.valid  = 1'b1;
        in_if.data   = 128'h0123456789abcdef0123456789abcdef;
        in_if.sop    = 1'b1;
        in_if.eop    = 1'b1;
        in_if.empty  = 4'h0;
        out_if.rdy   = 1'b1;
        zd           = '0;

        vecs[0] = '{key: FIPS_KEY, sync: FIPS_SYNC, data: zd, nbeats: 1, stall: 0,
                    fixed0: FIPS_CT, use_fixed: 1'b1};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    sync: 128'h3243f6a8885a308d313198a2e0370734,
                    data: {128'h0, 128'hcafef00d_00000000_ffffffff_12345678,
                           128'hdeadbeef_01020304_a5a5a5a5_5a5a5a5a, 128'h0},
                    nbeats: 3, stall: 0,
                    fixed0: 128'h3925841d02dc09fbdc118597196a0b32, use_fixed: 1'b1};
        vecs[2] = '{key: FIPS_KEY, sync: 128'h0123456789abcdef01234567ffffffff,
                    data: {128'h0, 128'h0, 128'h11111111_22222222_33333333_44444444, 128'h0},
                    nbeats: 2, stall: 5, fixed0: 128'h0, use_fixed: 1'b0};
        vecs[3] = '{key: {$urandom, $urandom, $urandom, $urandom},
                    sync: {$urandom, $urandom, $urandom, $urandom},
                    data: {128'h0, 128'h0, {$urandom, $urandom, $urandom, $urandom},
                           {$urandom, $urandom, $urandom, $urandom}},
                    nbeats: 2, stall: 0, fixed0: 128'h0, use_fixed: 1'b0};

        // Reset state, with a beat offered and downstream ready.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_key_rdy",   {127'h0, ks_if.rdy},    128'h1);
        chk("reset_in_rdy",    {127'h0, in_if.rdy},    128'h0);
        chk("reset_out_valid", {127'h0, out_if.valid}, 128'h0);
        chk("reset_dsync",     {127'h0, double_sync},  128'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // FIPS-197 vector with latency: beat already offered before the load.
        e = '{data: FIPS_CT, sop: 1'b1, eop: 1'b1, empty: 4'h0};
        exp_q.push_back(e);
        in_if.data = 128'h0;
        key_load(FIPS_KEY, FIPS_SYNC);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 10) chk("latency_valid_at_10", {127'h0, out_if.valid}, 128'h0);
            if (k == 11) chk("latency_valid_at_11", {127'h0, out_if.valid}, 128'h1);
        end
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        @(negedge clk);
        chk("fips_idle_after_eop", {127'h0, ks_if.rdy}, 128'h1);
        $display("txn fips_latency done");

        // Table-driven messages.
        for (int v = 0; v < 4; v++) begin
            key_load(vecs[v].key, vecs[v].sync);
            send_beats(vecs[v].key, vecs[v].sync, vecs[v].data, vecs[v].nbeats,
                       vecs[v].stall, vecs[v].fixed0, vecs[v].use_fixed);
            $display("txn vector %0d: %0d beats, stall %0d", v, vecs[v].nbeats, vecs[v].stall);
        end

        // Key/sync offered mid-encryption is flagged and ignored.
        key_load(vecs[1].key, vecs[1].sync);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ks_if.valid = 1'b1;
        ks_if.key   = 128'hffeeddccbbaa99887766554433221100;
        ks_if.sync  = 128'h0;
        @(negedge clk);
        chk("dsync_before", {127'h0, double_sync}, 128'h0);
        @(posedge clk); #1;
        ks_if.valid = 1'b0;
        @(negedge clk);
        chk("dsync_pulse", {127'h0, double_sync}, 128'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("dsync_clear", {127'h0, double_sync}, 128'h0);
        send_beats(vecs[1].key, vecs[1].sync, vecs[1].data, 2, 0, vecs[1].fixed0, 1'b1);
        $display("txn double_sync done");

        // Reset at round 4 with a beat offered.
        key_load(FIPS_KEY, FIPS_SYNC);
        repeat (4) begin
            @(posedge clk); #1;
        end
        in_if.valid = 1'b1;
        in_if.data  = 128'h0;
        in_if.sop   = 1'b1;
        in_if.eop   = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_key_rdy",   {127'h0, ks_if.rdy},    128'h1);
        chk("rst_in_rdy",    {127'h0, in_if.rdy},    128'h0);
        chk("rst_out_valid", {127'h0, out_if.valid}, 128'h0);
        chk("rst_dsync",     {127'h0, double_sync},  128'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        leak = 1'b0;
        for (n = 0; n < 15; n++) begin
            @(negedge clk);
            if (out_if.valid || in_if.rdy) leak = 1'b1;
        end
        chk("no_beat_without_key", {127'h0, leak}, 128'h0);
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        key_load(FIPS_KEY, FIPS_SYNC);
        send_beats(FIPS_KEY, FIPS_SYNC, zd, 1, 0, FIPS_CT, 1'b1);
        $display("txn reset_recovery done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
